// File: rtl/regbus_arbiter.sv
// Two-master round-robin arbiter for a single register-bus slave.
// Only one slave transaction is in flight; reads that never return are completed with an error.
module regbus_arbiter #(
    parameter int          TIMEOUT  = 4,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rerr,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rerr,
    output logic        wr_en,
    output logic [3:0]  be,
    output logic [15:0] wr_addr,
    output logic [31:0] wdata,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [31:0] rdata,
    input  logic        rd_rdy
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, RD_WAIT, RETURN} state_t;

    state_t      state_reg, state_next;
    logic        winner_reg, winner_next;       // 0 = m0, 1 = m1
    logic        last_gnt_reg, last_gnt_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        gnt0_reg, gnt0_next, gnt1_reg, gnt1_next;
    logic        rvalid0_reg, rvalid0_next, rvalid1_reg, rvalid1_next;
    logic        rerr0_reg, rerr0_next, rerr1_reg, rerr1_next;
    logic [31:0] rdata0_reg, rdata0_next, rdata1_reg, rdata1_next;
    logic        wr_en_reg, wr_en_next, rd_en_reg, rd_en_next;
    logic [3:0]  be_reg, be_next;
    logic [15:0] wr_addr_reg, wr_addr_next, rd_addr_reg, rd_addr_next;
    logic [31:0] wdata_reg, wdata_next;

    logic any_req, sel, sel_we, timeout_hit;

    // On a tie the master that was not granted last wins.
    assign any_req     = m0_req | m1_req;
    assign sel         = (m0_req & m1_req) ? ~last_gnt_reg : m1_req;
    assign sel_we      = sel ? m1_we : m0_we;
    assign timeout_hit = (cnt_reg + 4'd1) == TIMEOUT_CNT;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg    <= IDLE;
            winner_reg   <= 1'b0;
            last_gnt_reg <= 1'b1;
            cnt_reg      <= 4'd0;
            gnt0_reg     <= 1'b0;
            gnt1_reg     <= 1'b0;
            rvalid0_reg  <= 1'b0;
            rvalid1_reg  <= 1'b0;
            rerr0_reg    <= 1'b0;
            rerr1_reg    <= 1'b0;
            rdata0_reg   <= 32'd0;
            rdata1_reg   <= 32'd0;
            wr_en_reg    <= 1'b0;
            rd_en_reg    <= 1'b0;
            be_reg       <= 4'd0;
            wr_addr_reg  <= 16'd0;
            rd_addr_reg  <= 16'd0;
            wdata_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            winner_reg   <= winner_next;
            last_gnt_reg <= last_gnt_next;
            cnt_reg      <= cnt_next;
            gnt0_reg     <= gnt0_next;
            gnt1_reg     <= gnt1_next;
            rvalid0_reg  <= rvalid0_next;
            rvalid1_reg  <= rvalid1_next;
            rerr0_reg    <= rerr0_next;
            rerr1_reg    <= rerr1_next;
            rdata0_reg   <= rdata0_next;
            rdata1_reg   <= rdata1_next;
            wr_en_reg    <= wr_en_next;
            rd_en_reg    <= rd_en_next;
            be_reg       <= be_next;
            wr_addr_reg  <= wr_addr_next;
            rd_addr_reg  <= rd_addr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (any_req) state_next = sel_we ? ISSUE_WR : ISSUE_RD;
            ISSUE_WR: state_next = IDLE;
            ISSUE_RD: state_next = RD_WAIT;
            RD_WAIT:  if (rd_rdy || timeout_hit) state_next = RETURN;
            RETURN:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes are computed one cycle ahead so they appear registered in the matching state.
    always_comb begin
        winner_next   = winner_reg;
        last_gnt_next = last_gnt_reg;
        cnt_next      = cnt_reg;
        gnt0_next     = 1'b0;
        gnt1_next     = 1'b0;
        rvalid0_next  = 1'b0;
        rvalid1_next  = 1'b0;
        rerr0_next    = 1'b0;
        rerr1_next    = 1'b0;
        rdata0_next   = rdata0_reg;
        rdata1_next   = rdata1_reg;
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        be_next       = be_reg;
        wr_addr_next  = wr_addr_reg;
        rd_addr_next  = rd_addr_reg;
        wdata_next    = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    winner_next = sel;
                    gnt0_next   = ~sel;
                    gnt1_next   = sel;
                    if (sel_we) begin
                        wr_en_next   = 1'b1;
                        be_next      = sel ? m1_be    : m0_be;
                        wr_addr_next = sel ? m1_addr  : m0_addr;
                        wdata_next   = sel ? m1_wdata : m0_wdata;
                    end else begin
                        rd_en_next   = 1'b1;
                        rd_addr_next = sel ? m1_addr : m0_addr;
                    end
                end
            end
            ISSUE_WR: last_gnt_next = winner_reg;
            ISSUE_RD: begin
                last_gnt_next = winner_reg;
                cnt_next      = 4'd0;
            end
            RD_WAIT: begin
                if (rd_rdy) begin
                    rvalid0_next = ~winner_reg;
                    rvalid1_next = winner_reg;
                    if (winner_reg) rdata1_next = rdata;
                    else            rdata0_next = rdata;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                    if (timeout_hit) begin
                        rvalid0_next = ~winner_reg;
                        rvalid1_next = winner_reg;
                        rerr0_next   = ~winner_reg;
                        rerr1_next   = winner_reg;
                        if (winner_reg) rdata1_next = ERR_DATA;
                        else            rdata0_next = ERR_DATA;
                    end
                end
            end
            default: ;
        endcase
    end

    assign m0_gnt    = gnt0_reg;
    assign m1_gnt    = gnt1_reg;
    assign m0_rvalid = rvalid0_reg;
    assign m1_rvalid = rvalid1_reg;
    assign m0_rerr   = rerr0_reg;
    assign m1_rerr   = rerr1_reg;
    assign m0_rdata  = rdata0_reg;
    assign m1_rdata  = rdata1_reg;
    assign wr_en     = wr_en_reg;
    assign rd_en     = rd_en_reg;
    assign be        = be_reg;
    assign wr_addr   = wr_addr_reg;
    assign rd_addr   = rd_addr_reg;
    assign wdata     = wdata_reg;

endmodule
